// File: rtl/iterative_shift_unit_if.sv
// Request/response bundle for iterative_shift_unit: a valid/ready request channel
// and a valid/ready result channel. shift_type carries the 2-bit ALU shift encoding.
interface iterative_shift_unit_if #(
  parameter int N = 32
);
  localparam int SW = $clog2(N);

  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  a;
  logic [SW-1:0] shamt;
  logic [1:0]    shift_type;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  r;
  logic          busy;

  modport master (
    output in_valid, a, shamt, shift_type, out_ready,
    input  in_ready, out_valid, r, busy
  );

  modport slave (
    input  in_valid, a, shamt, shift_type, out_ready,
    output in_ready, out_valid, r, busy
  );
endinterface

// File: rtl/iterative_shift_unit.sv
// Multi-cycle shifter: STEP bits per cycle, encoding 00 SRL, 10 SRA, 01 SLL, 11 ROR.
// Macro SHIFT_ROTATE_EN enables rotate-right; without it type 11 passes the operand through.
module iterative_shift_unit #(
  parameter int N    = 32,
  parameter int STEP = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  iterative_shift_unit_if.slave bus
);
  localparam int SW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  logic [SW-1:0] rem;
  logic [1:0]    op;
  logic [N-1:0]  r_q;
  logic          out_valid_q;
  logic          busy_q;
  logic [SW-1:0] k;
  logic          pass;

  function automatic logic [N-1:0] step_shift(input logic [N-1:0] v,
                                              input logic [1:0]   t,
                                              input logic [SW-1:0] amt);
    logic signed [N-1:0] sv;
    sv = $signed(v);
    case (t)
      2'b00:   step_shift = v >> amt;
      2'b10:   step_shift = sv >>> amt;
      2'b01:   step_shift = v << amt;
`ifdef SHIFT_ROTATE_EN
      default: step_shift = (v >> amt) | (v << (N - int'(amt)));
`else
      default: step_shift = v;
`endif
    endcase
  endfunction

`ifdef SHIFT_ROTATE_EN
  assign pass = 1'b0;
`else
  assign pass = (bus.shift_type == 2'b11);
`endif

  // Last step may be shorter than STEP when the amount is not a multiple of it.
  assign k = (rem < SW'(STEP)) ? rem : SW'(STEP);

  assign bus.in_ready  = !rst && (state == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.r         = r_q;
  assign bus.busy      = busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rem         <= '0;
      op          <= 2'b00;
      r_q         <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            r_q    <= bus.a;
            op     <= bus.shift_type;
            busy_q <= 1'b1;
            if (bus.shamt == '0 || pass) begin
              rem         <= '0;
              state       <= DONE;
              out_valid_q <= 1'b1;
            end else begin
              rem   <= bus.shamt;
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          r_q <= step_shift(r_q, op, k);
          rem <= rem - k;
          if (rem == k) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_iterative_shift_unit.sv
// Directed bench for iterative_shift_unit: STEP=1 instance checked every cycle against
// a behavioural model, plus a STEP=4 instance checked with literal expectations.
module tb_iterative_shift_unit;
  localparam int N  = 32;
  localparam int SW = $clog2(N);

  logic clk = 1'b0;
  logic rst = 1'b1;

  iterative_shift_unit_if #(.N(N)) ifc ();
  iterative_shift_unit_if #(.N(N)) ifc4 ();

  iterative_shift_unit #(.N(N), .STEP(1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  iterative_shift_unit #(.N(N), .STEP(4)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (ifc4.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] ref_shift(input logic [N-1:0] v, input int sh, input logic [1:0] t);
    logic signed [N-1:0] sv;
    sv = $signed(v);
    case (t)
      2'b00:   return v >> sh;
      2'b10:   return sv >>> sh;
      2'b01:   return v << sh;
`ifdef SHIFT_ROTATE_EN
      default: return (sh == 0) ? v : ((v >> sh) | (v << (N - sh)));
`else
      default: return v;
`endif
    endcase
  endfunction

  // Edges after the accept edge until the result is presented.
  function automatic int ref_edges(input int sh, input logic [1:0] t, input int step);
`ifndef SHIFT_ROTATE_EN
    if (t == 2'b11) return 0;
`endif
    return (sh + step - 1) / step;
  endfunction

  // Behavioural model of the STEP=1 instance, advanced on every rising edge.
  logic         m_busy  = 1'b0;
  logic         m_valid = 1'b0;
  logic         m_known = 1'b1;
  logic [N-1:0] m_r     = '0;
  logic [N-1:0] m_res   = '0;
  int           m_wait  = 0;
  logic         cmp_en  = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy  = 1'b0;
      m_valid = 1'b0;
      m_known = 1'b1;
      m_r     = '0;
    end else if (!m_busy) begin
      if (ifc.in_valid) begin
        m_busy = 1'b1;
        m_res  = ref_shift(ifc.a, int'(ifc.shamt), ifc.shift_type);
        m_wait = ref_edges(int'(ifc.shamt), ifc.shift_type, 1);
        if (m_wait == 0) begin
          m_valid = 1'b1;
          m_r     = m_res;
        end else begin
          m_known = 1'b0;
        end
      end
    end else if (!m_valid) begin
      m_wait--;
      if (m_wait == 0) begin
        m_valid = 1'b1;
        m_r     = m_res;
        m_known = 1'b1;
      end
    end else if (ifc.out_ready) begin
      m_valid = 1'b0;
      m_busy  = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc in_ready", N'(ifc.in_ready), N'(!rst && !m_busy));
      check("cyc out_valid", N'(ifc.out_valid), N'(m_valid));
      check("cyc busy", N'(ifc.busy), N'(m_busy));
      if (m_known) check("cyc r", ifc.r, m_r);
    end
  end

  task automatic do_op(input string name, input logic [N-1:0] av, input logic [SW-1:0] sh,
                       input logic [1:0] t, input logic [N-1:0] exp_r, input int exp_edges,
                       input int hold);
    int n;
    @(posedge clk); #1;
    ifc.a = av; ifc.shamt = sh; ifc.shift_type = t; ifc.in_valid = 1'b1;
    @(negedge clk);
    check({name, " in_ready"}, N'(ifc.in_ready), N'(1'b1));
    @(posedge clk); #1;
    ifc.in_valid = 1'b0; ifc.a = ~av; ifc.shamt = ~sh; ifc.shift_type = ~t;
    n = 0;
    @(negedge clk);
    while (!ifc.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, " edges"}, N'(n), N'(exp_edges));
    check({name, " r"}, ifc.r, exp_r);
    if (hold > 0) begin
      @(posedge clk); #1;
      ifc.in_valid = 1'b1;
      repeat (hold) @(posedge clk);
      #1;
      @(negedge clk);
      check({name, " hold out_valid"}, N'(ifc.out_valid), N'(1'b1));
      check({name, " hold in_ready"}, N'(ifc.in_ready), N'(1'b0));
      check({name, " hold r"}, ifc.r, exp_r);
    end
    @(posedge clk); #1;
    ifc.in_valid = 1'b0; ifc.out_ready = 1'b1;
    @(posedge clk); #1;
    ifc.out_ready = 1'b0;
    @(negedge clk);
    check({name, " release out_valid"}, N'(ifc.out_valid), N'(1'b0));
    check({name, " release in_ready"}, N'(ifc.in_ready), N'(1'b1));
    check({name, " release r"}, ifc.r, exp_r);
  endtask

  task automatic do_op4(input string name, input logic [N-1:0] av, input logic [SW-1:0] sh,
                        input logic [1:0] t, input logic [N-1:0] exp_r, input int exp_edges);
    int n;
    @(posedge clk); #1;
    ifc4.a = av; ifc4.shamt = sh; ifc4.shift_type = t; ifc4.in_valid = 1'b1;
    @(posedge clk); #1;
    ifc4.in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!ifc4.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, " edges"}, N'(n), N'(exp_edges));
    check({name, " r"}, ifc4.r, exp_r);
    @(posedge clk); #1;
    ifc4.out_ready = 1'b1;
    @(posedge clk); #1;
    ifc4.out_ready = 1'b0;
    @(negedge clk);
    check({name, " release in_ready"}, N'(ifc4.in_ready), N'(1'b1));
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    ifc.in_valid = 1'b0; ifc.out_ready = 1'b0; ifc.a = '0; ifc.shamt = '0; ifc.shift_type = 2'b00;
    ifc4.in_valid = 1'b0; ifc4.out_ready = 1'b0; ifc4.a = '0; ifc4.shamt = '0; ifc4.shift_type = 2'b00;
    rst = 1'b1;

    // Model pins against hand-computed values.
    check("pin srl", ref_shift(32'h80000000, 4, 2'b00), 32'h08000000);
    check("pin sra", ref_shift(32'h80000000, 31, 2'b10), 32'hFFFFFFFF);
    check("pin sll", ref_shift(32'h0000ABCD, 16, 2'b01), 32'hABCD0000);
    check("pin edges step4", N'(ref_edges(31, 2'b10, 4)), N'(8));

    repeat (3) @(posedge clk);
    #1;
    cmp_en = 1'b1;
    @(negedge clk);
    check("reset r", ifc.r, '0);
    check("reset out_valid", N'(ifc.out_valid), '0);
    check("reset busy", N'(ifc.busy), '0);
    check("reset in_ready while rst", N'(ifc.in_ready), '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle in_ready", N'(ifc.in_ready), N'(1'b1));

    do_op("srl4", 32'h80000000, 5'd4, 2'b00, 32'h08000000, 4, 0);
    do_op("sra31", 32'h80000000, 5'd31, 2'b10, 32'hFFFFFFFF, 31, 0);
    do_op("sll0", 32'h0000ABCD, 5'd0, 2'b01, 32'h0000ABCD, 0, 0);
    do_op("sll16", 32'h0000ABCD, 5'd16, 2'b01, 32'hABCD0000, 16, 0);
    do_op("sra_pos_hold", 32'h7F000000, 5'd8, 2'b10, 32'h007F0000, 8, 5);
    do_op("srl31", 32'hFFFFFFFF, 5'd31, 2'b00, 32'h00000001, 31, 0);
`ifdef SHIFT_ROTATE_EN
    do_op("ror1", 32'h00000001, 5'd1, 2'b11, 32'h80000000, 1, 0);
    do_op("ror4", 32'h12345678, 5'd4, 2'b11, 32'h81234567, 4, 0);
`else
    do_op("pass1", 32'h00000001, 5'd1, 2'b11, 32'h00000001, 0, 0);
    do_op("pass4", 32'h12345678, 5'd4, 2'b11, 32'h12345678, 0, 0);
`endif

    // Reset during the third SHIFT cycle of SRL by 20.
    @(posedge clk); #1;
    ifc.a = 32'hF0F0F0F0; ifc.shamt = 5'd20; ifc.shift_type = 2'b00; ifc.in_valid = 1'b1;
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort out_valid", N'(ifc.out_valid), '0);
    check("abort r", ifc.r, '0);
    check("abort in_ready", N'(ifc.in_ready), N'(1'b1));
    check("abort busy", N'(ifc.busy), '0);

    // Reset and request together: nothing is accepted.
    @(posedge clk); #1;
    rst = 1'b1; ifc.in_valid = 1'b1; ifc.a = 32'h12345678; ifc.shamt = 5'd3;
    @(posedge clk); #1;
    rst = 1'b0; ifc.in_valid = 1'b0;
    @(negedge clk);
    check("rst+req busy", N'(ifc.busy), '0);
    check("rst+req in_ready", N'(ifc.in_ready), N'(1'b1));

    do_op("srl20 after abort", 32'hF0F0F0F0, 5'd20, 2'b00, 32'h00000F0F, 20, 0);

    do_op4("s4 sra31", 32'h80000000, 5'd31, 2'b10, 32'hFFFFFFFF, 8);
    do_op4("s4 sll5", 32'h0000ABCD, 5'd5, 2'b01, 32'h001579A0, 2);
    do_op4("s4 srl4", 32'h80000000, 5'd4, 2'b00, 32'h08000000, 1);
    do_op4("s4 sra0", 32'h80000001, 5'd0, 2'b10, 32'h80000001, 0);

    repeat (2) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
